mmio_perf_ctrl: RTL

//  Front-end controller for the performance-counter bank, sitting on the MEM-stage data port between the CPU and the Dcache.

---
 rtl/mmio_perf_ctrl_pkg.sv | 39 +++
 rtl/mmio_perf_ctrl_decode.sv | 35 +++
 rtl/mmio_perf_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mmio_perf_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : lc3b_types
//  Description : Shared types and constants for the MMIO performance-counter
//                front end: controller state encoding, MMIO window location,
//                control-register offset and named counter indices.
//  Revision    : 1.0 - initial release
// ============================================================================
package lc3b_types;

    // Controller states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CACHE   = 3'd1,
        MMIO_RD = 3'd2,
        MMIO_WR = 3'd3,
        RESP    = 3'd4
    } mmio_perf_state_t;

    // MMIO window: 32 bytes starting at a 32-byte aligned base
    localparam logic [15:0] MMIO_BASE         = 16'hFFE0;
    localparam logic [4:0]  MMIO_CTRL_OFFSET  = 5'h1E;
    localparam int          PERF_NUM_COUNTERS = 11;

    // Counter indices inside the bank (address = MMIO_BASE + 2*index)
    localparam logic [3:0] ICACHE_MISS  = 4'h0;
    localparam logic [3:0] ICACHE_HIT   = 4'h1;
    localparam logic [3:0] DCACHE_MISS  = 4'h2;
    localparam logic [3:0] DCACHE_HIT   = 4'h3;
    localparam logic [3:0] L2_MISS      = 4'h4;
    localparam logic [3:0] L2_HIT       = 4'h5;
    localparam logic [3:0] BR_TOTAL     = 4'h6;
    localparam logic [3:0] BR_MISPRED   = 4'h7;
    localparam logic [3:0] STALL_TOTAL  = 4'h8;
    localparam logic [3:0] STALL_MEM    = 4'h9;
    localparam logic [3:0] STALL_PCIFID = 4'hA;

endpackage : lc3b_types
`default_nettype wire

// File: rtl/mmio_perf_ctrl_decode.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_perf_decode
//  Description : Combinational address decoder for the performance-counter
//                MMIO window.
//    address  in  16  CPU data address
//    is_mmio  out 1   address falls inside the 32-byte window
//    idx      out 4   half-word index inside the window
//    is_ctrl  out 1   address is the control register
//    in_range out 1   idx selects an implemented counter
//  Revision    : 1.0 - initial release
// ============================================================================
module mmio_perf_decode #(
    parameter logic [15:0] BASE         = 16'hFFE0,
    parameter logic [4:0]  CTRL_OFFSET  = 5'h1E,
    parameter int          NUM_COUNTERS = 11
) (
    input  logic [15:0] address,
    output logic        is_mmio,
    output logic [3:0]  idx,
    output logic        is_ctrl,
    output logic        in_range
);
    import lc3b_types::*;

    // Five bits so that a full bank of 16 counters is still representable
    localparam logic [4:0] c_num_counters = 5'(NUM_COUNTERS);

    assign is_mmio  = (address[15:5] == BASE[15:5]);
    assign idx      = address[4:1];
    assign is_ctrl  = (address[4:0] == CTRL_OFFSET);
    assign in_range = ({1'b0, address[4:1]} < c_num_counters);

endmodule : mmio_perf_decode
`default_nettype wire

// File: rtl/mmio_perf_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_perf_ctrl
//  Description : MEM-stage front end for the performance-counter bank.
//                Cacheable accesses are passed straight through to the Dcache
//                with no added latency; MMIO accesses are sequenced as
//                IDLE -> MMIO_RD/MMIO_WR -> RESP. Owns the freeze bit and the
//                clear-all strobe.
//    clk, reset                    clock, synchronous active-high reset
//    mem_*                         CPU data port
//    dcache_*                      forwarded Dcache port
//    counter, MMIO_read,
//    MMIO_write, counter_out       counter-bank select / read / clear
//    count_en, clear_all           bank-wide enable and clear strobe
//  Revision    : 1.0 - initial release
// ============================================================================
module mmio_perf_ctrl #(
    parameter logic [15:0] MMIO_BASE    = lc3b_types::MMIO_BASE,
    parameter int          NUM_COUNTERS = lc3b_types::PERF_NUM_COUNTERS,
    parameter logic [4:0]  CTRL_OFFSET  = lc3b_types::MMIO_CTRL_OFFSET
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] mem_address,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [15:0] mem_wdata,
    input  logic [1:0]  mem_byte_enable,
    output logic [15:0] mem_rdata,
    output logic        mem_resp,
    output logic        dcache_read,
    output logic        dcache_write,
    input  logic [15:0] dcache_rdata,
    input  logic        dcache_resp,
    output logic [3:0]  counter,
    output logic        MMIO_read,
    output logic        MMIO_write,
    input  logic [15:0] counter_out,
    output logic        count_en,
    output logic        clear_all
);
    import lc3b_types::*;

    localparam logic [7:0] c_num_counters8 = 8'(NUM_COUNTERS);

    mmio_perf_state_t r_state;
    logic [3:0]       r_counter;
    logic [15:0]      r_rdata;
    logic             r_freeze;
    logic             r_mmio_read;
    logic             r_mmio_write;
    logic             r_clear_all;
    logic             r_resp;

    logic             w_is_mmio;
    logic [3:0]       w_idx;
    logic             w_is_ctrl;
    logic             w_in_range;
    logic             w_req;
    logic             w_fwd;
    logic             w_unused_wdata;

    mmio_perf_decode #(
        .BASE         (MMIO_BASE),
        .CTRL_OFFSET  (CTRL_OFFSET),
        .NUM_COUNTERS (NUM_COUNTERS)
    ) u_decode (
        .address  (mem_address),
        .is_mmio  (w_is_mmio),
        .idx      (w_idx),
        .is_ctrl  (w_is_ctrl),
        .in_range (w_in_range)
    );

    // Only the freeze and clear-all bits of the control register exist
    assign w_unused_wdata = ^mem_wdata[15:2];

    assign w_req = mem_read | mem_write;

    // Pass-through is active from the request cycle itself so the Dcache
    // sees the access with no extra cycle in front of it.
    assign w_fwd = ((r_state == IDLE) && w_req && !w_is_mmio) || (r_state == CACHE);

    // A simultaneous read and write is treated as a write
    assign dcache_read  = w_fwd & mem_read & ~mem_write;
    assign dcache_write = w_fwd & mem_write;

    assign mem_resp  = w_fwd ? dcache_resp  : r_resp;
    assign mem_rdata = w_fwd ? dcache_rdata : r_rdata;

    assign counter    = r_counter;
    assign MMIO_read  = r_mmio_read;
    assign MMIO_write = r_mmio_write;
    assign clear_all  = r_clear_all;
    assign count_en   = ~r_freeze;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_counter    <= 4'h0;
            r_rdata      <= 16'h0000;
            r_freeze     <= 1'b0;
            r_mmio_read  <= 1'b0;
            r_mmio_write <= 1'b0;
            r_clear_all  <= 1'b0;
            r_resp       <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-armed below
            r_mmio_read  <= 1'b0;
            r_mmio_write <= 1'b0;
            r_clear_all  <= 1'b0;
            r_resp       <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        if (!w_is_mmio) begin
                            // A same-cycle Dcache hit completes without leaving IDLE
                            if (!dcache_resp) begin
                                r_state <= CACHE;
                            end
                        end else if (mem_write) begin
                            r_state   <= MMIO_WR;
                            r_counter <= w_idx;
                            if (mem_byte_enable != 2'b00) begin
                                if (w_in_range) begin
                                    r_mmio_write <= 1'b1;
                                end else if (w_is_ctrl) begin
                                    r_freeze    <= mem_wdata[0];
                                    r_clear_all <= mem_wdata[1];
                                end
                            end
                        end else begin
                            r_state     <= MMIO_RD;
                            r_counter   <= w_idx;
                            r_mmio_read <= 1'b1;
                        end
                    end
                end
                CACHE: begin
                    if (dcache_resp) begin
                        r_state <= IDLE;
                    end
                end
                MMIO_RD: begin
                    // Address is held by the CPU, so the decode is still valid here
                    if (w_in_range) begin
                        r_rdata <= counter_out;
                    end else if (w_is_ctrl) begin
                        r_rdata <= {c_num_counters8, 7'b0, r_freeze};
                    end else begin
                        r_rdata <= 16'h0000;
                    end
                    r_state <= RESP;
                    r_resp  <= 1'b1;
                end
                MMIO_WR: begin
                    r_state <= RESP;
                    r_resp  <= 1'b1;
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : mmio_perf_ctrl
`default_nettype wire
